// File: rtl/rom_dl_ctrl_if.sv
// Download-side bus between data_io, the download controller and the core's ROM write port.
`timescale 1ns/1ps
interface rom_dl_ctrl_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        slot_busy;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, slot_busy,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, slot_busy,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: buffers download bytes, issues them into free ROM write slots,
// and holds the Pacman core in reset until a complete image has been written.
`timescale 1ns/1ps
module rom_dl_ctrl #(
    parameter int ROM_SIZE   = 65536,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_HOLD   = 1024,
    parameter int ROM_INDEX  = 0
) (
    input  logic         clk_sys,
    input  logic         reset,
    rom_dl_ctrl_if.slave bus,
    input  logic         user_reset,
    output logic         core_reset,
    output logic         rom_loaded,
    output logic         overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int EW = 24;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [16:0]   byte_cnt_q, byte_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [15:0]   last_addr_q, last_addr_d;
    logic [7:0]    last_data_q, last_data_d;
    logic          dl_prev_q;
    logic          core_reset_q, core_reset_d;
    logic          rom_loaded_q, rom_loaded_d;
    logic          overflow_q, overflow_d;

    logic          fifo_empty, fifo_full;
    logic          rom_sel, in_range, push_req, push, pop, rise_rom;
    logic [EW-1:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rom_sel  = (bus.ioctl_index == 8'(ROM_INDEX));
    assign in_range = ({7'd0, bus.ioctl_addr} < 32'(ROM_SIZE));
    assign push_req = bus.ioctl_wr & bus.ioctl_download & rom_sel & in_range;
    assign push     = push_req & ~fifo_full;
    assign pop      = ~fifo_empty & ~bus.slot_busy;
    assign rise_rom = bus.ioctl_download & ~dl_prev_q & rom_sel;
    assign head     = fifo_mem_q[rd_ptr_q[AW-1:0]];

    // Issue is decided in the same cycle as slot_busy so a free slot is never wasted.
    assign bus.dn_wr   = pop;
    assign bus.dn_addr = pop ? head[23:8] : last_addr_q;
    assign bus.dn_data = pop ? head[7:0]  : last_data_q;

    assign core_reset = core_reset_q;
    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.ioctl_addr[15:0], bus.ioctl_dout};
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        rom_loaded_d = rom_loaded_q;
        byte_cnt_d   = byte_cnt_q;
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        overflow_d   = overflow_q | (push_req & fifo_full);
        last_addr_d  = bus.dn_addr;
        last_data_d  = bus.dn_data;

        if (push && (byte_cnt_q != '1)) begin
            byte_cnt_d = byte_cnt_q + 17'd1;
        end

        case (state_q)
            IDLE, RUN: begin
                if (rise_rom) state_d = LOAD;
            end
            LOAD: begin
                if (!bus.ioctl_download) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    if (byte_cnt_q != '0) begin
                        state_d      = HOLD;
                        hold_cnt_d   = '0;
                        rom_loaded_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (rise_rom) begin
                    state_d = LOAD;
                end else if (hold_cnt_q == HW'(RST_HOLD - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh image starts its byte count at entry, including a byte on the entry cycle.
        if ((state_d == LOAD) && (state_q != LOAD)) begin
            byte_cnt_d = {16'd0, push};
        end

        core_reset_d = (state_d != RUN) | user_reset | ~rom_loaded_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
            dl_prev_q    <= 1'b0;
            core_reset_q <= 1'b1;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            dl_prev_q    <= bus.ioctl_download;
            core_reset_q <= core_reset_d;
            rom_loaded_q <= rom_loaded_d;
            overflow_q   <= overflow_d;
        end
    end
endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl: download sequencing, slot arbitration, overflow and reset handling.
`timescale 1ns/1ps
module tb_rom_dl_ctrl;
    localparam int RST_HOLD = 16;

    logic clk_sys    = 1'b0;
    logic reset      = 1'b1;
    logic user_reset = 1'b0;
    logic core_reset, rom_loaded, overflow;

    rom_dl_ctrl_if bus();

    rom_dl_ctrl #(
        .ROM_SIZE  (65536),
        .FIFO_DEPTH(4),
        .RST_HOLD  (RST_HOLD),
        .ROM_INDEX (0)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus),
        .user_reset(user_reset),
        .core_reset(core_reset),
        .rom_loaded(rom_loaded),
        .overflow  (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_mode = 0;   // 0: free, 1: busy every 4th cycle, 2: busy always

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int   last_wr_cyc = -1;
    int   busy_viol   = 0;
    int   cr_hi       = 0;
    int   cr_rise     = -1;
    logic cr_prev     = 1'b1;

    always @(negedge clk_sys) begin
        if (bus.dn_wr === 1'b1) begin
            wa_q.push_back(bus.dn_addr);
            wd_q.push_back(bus.dn_data);
            last_wr_cyc = cyc;
            if (bus.slot_busy) busy_viol++;
            $display("cyc %0d dn_wr addr=%04h data=%02h", cyc, bus.dn_addr, bus.dn_data);
        end
        if (core_reset) cr_hi++;
        if (core_reset && !cr_prev) cr_rise = cyc;
        cr_prev = core_reset;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
        bus.ioctl_wr = 1'b0;
        case (busy_mode)
            1:       bus.slot_busy = ((cyc % 4) == 3);
            2:       bus.slot_busy = 1'b1;
            default: bus.slot_busy = 1'b0;
        endcase
    endtask

    task automatic wait_core_run(input int budget, output int fall);
        fall = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!core_reset) begin
                fall = cyc;
                break;
            end
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    function automatic logic [31:0] wa_at(input int i);
        return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        return (i < wd_q.size()) ? 32'(wd_q[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, fall, e, u;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.slot_busy      = 1'b0;

        // Reset, then idle
        repeat (3) step();
        reset = 1'b0;
        repeat (100) step();
        check_eq("idle_core_reset", 32'(core_reset), 32'd1);
        check_eq("idle_rom_loaded", 32'(rom_loaded), 32'd0);
        check_eq("idle_overflow",   32'(overflow),   32'd0);
        check_eq("idle_dn_addr",    32'(bus.dn_addr), 32'd0);
        check_eq("idle_dn_data",    32'(bus.dn_data), 32'd0);
        check_eq("idle_wr_count",   32'(wa_q.size()), 32'd0);

        // 16-byte image, one byte per 3 cycles, slot busy 1 in 4
        busy_mode = 1;
        step();
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        for (int i = 0; i < 16; i++) begin
            step();
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'(8'hA0 + i);
            step();
            step();
        end
        step();
        bus.ioctl_download = 1'b0;
        f = cyc;
        wait_core_run(200, fall);
        e = ((last_wr_cyc + 1) > (f + 1)) ? (last_wr_cyc + 1) : (f + 1);
        check_eq("load_wr_count", 32'(wa_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("load_addr[%0d]", i), wa_at(i), 32'(i));
            check_eq($sformatf("load_data[%0d]", i), wd_at(i), 32'(8'hA0 + i));
        end
        check_eq("load_busy_viol",  32'(busy_viol),  32'd0);
        check_eq("load_rom_loaded", 32'(rom_loaded), 32'd1);
        check_eq("load_overflow",   32'(overflow),   32'd0);
        check_eq("load_reset_fall", 32'(fall),       32'(e + RST_HOLD + 1));

        // Burst of 6 while slot busy for 8 cycles: 4 kept, 2 dropped
        clear_log();
        busy_mode = 0;
        step();
        bus.ioctl_download = 1'b1;
        busy_mode = 2;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(8'h20 + i);
            bus.ioctl_dout = 8'(8'h50 + i);
        end
        step();
        step();
        busy_mode = 0;
        repeat (8) step();
        bus.ioctl_download = 1'b0;
        wait_core_run(200, fall);
        check_eq("burst_wr_count", 32'(wa_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("burst_addr[%0d]", i), wa_at(i), 32'(8'h20 + i));
            check_eq($sformatf("burst_data[%0d]", i), wd_at(i), 32'(8'h50 + i));
        end
        check_eq("burst_overflow",   32'(overflow),   32'd1);
        check_eq("burst_busy_viol",  32'(busy_viol),  32'd0);
        check_eq("burst_rom_loaded", 32'(rom_loaded), 32'd1);
        check_eq("burst_back_run",   32'(fall != -1), 32'd1);

        // Download for another index: ignored entirely
        clear_log();
        cr_hi = 0;
        step();
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd1;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'(i);
        end
        step();
        bus.ioctl_download = 1'b0;
        repeat (5) step();
        bus.ioctl_index = 8'd0;
        check_eq("idx1_wr_count",   32'(wa_q.size()), 32'd0);
        check_eq("idx1_core_hi",    32'(cr_hi),       32'd0);
        check_eq("idx1_rom_loaded", 32'(rom_loaded),  32'd1);

        // One-cycle user_reset while running
        cr_hi   = 0;
        cr_rise = -1;
        step();
        user_reset = 1'b1;
        u = cyc;
        step();
        user_reset = 1'b0;
        repeat (5) step();
        check_eq("ureset_hi_cycles", 32'(cr_hi),      32'd1);
        check_eq("ureset_rise_cyc",  32'(cr_rise),    32'(u + 1));
        check_eq("ureset_released",  32'(core_reset), 32'd0);

        // Out-of-range address: no bytes accepted, falls back to IDLE
        clear_log();
        step();
        bus.ioctl_download = 1'b1;
        step();
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h10000;
        bus.ioctl_dout = 8'h77;
        step();
        bus.ioctl_download = 1'b0;
        repeat (RST_HOLD + 10) step();
        check_eq("oor_wr_count",   32'(wa_q.size()), 32'd0);
        check_eq("oor_core_reset", 32'(core_reset),  32'd1);
        check_eq("oor_rom_loaded", 32'(rom_loaded),  32'd1);

        // Reset mid-LOAD with 3 bytes queued
        clear_log();
        busy_mode = 2;
        step();
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(8'h30 + i);
            bus.ioctl_dout = 8'(8'h90 + i);
        end
        step();
        check_eq("prerst_rom_loaded", 32'(rom_loaded), 32'd1);
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        step();
        reset = 1'b0;
        busy_mode = 0;
        repeat (20) step();
        check_eq("rst_wr_count",   32'(wa_q.size()), 32'd0);
        check_eq("rst_rom_loaded", 32'(rom_loaded),  32'd0);
        check_eq("rst_overflow",   32'(overflow),    32'd0);
        check_eq("rst_core_reset", 32'(core_reset),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
